oled_spi_arbiter: RTL and testbench

OLED_SPI_ARBITER -- requirements
Module: oled_spi_arbiter

---
 rtl/oled_spi_arbiter.sv | 127 ++++++++++++
 tb/tb_oled_spi_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_arbiter.sv
// oled_spi_arbiter: round-robin arbiter for three byte-stream requesters
// sharing a single write-only OLED SPI link (CS/SCLK/SDIN/DC). The owner
// keeps the bus, non-preemptively, until it drops its REQ between bytes.
module oled_spi_arbiter #(
  parameter int SCLK_HALF = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  REQ,
  output logic [2:0]  GNT,
  input  logic [2:0]  VALID,
  output logic [2:0]  RDY,
  input  logic [23:0] DATA_IN,
  input  logic [2:0]  DC_IN,
  output logic        CS,
  output logic        SCLK,
  output logic        SDIN,
  output logic        DC,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, RELEASE} state_t;

  // Last index of a half period; the counter is 8 bits wide and stops here,
  // so it never exceeds its width even at SCLK_HALF = 255.
  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  state_t     state;
  logic [1:0] owner;      // current owner, or last owner while idle
  logic [7:0] half_cnt;   // cycles elapsed in the current SCLK half / release
  logic [2:0] bit_cnt;    // bit index within the byte, 0 = MSB
  logic [7:0] shreg;      // byte being shifted, next bit at [6]
  logic [1:0] cand0, cand1, cand2, pick;
  logic [7:0] owner_byte;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin pick: search starts just after the last owner.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    cand0 = inc3(owner);
    cand1 = inc3(cand0);
    cand2 = inc3(cand1);
    if (REQ[cand0])      pick = cand0;
    else if (REQ[cand1]) pick = cand1;
    else                 pick = cand2;
    owner_byte = DATA_IN[{owner, 3'b000} +: 8];
  end

  // Control FSM with all link outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      owner    <= 2'd2;
      GNT      <= '0;
      RDY      <= '0;
      CS       <= 1'b1;
      SCLK     <= 1'b1;
      SDIN     <= 1'b0;
      DC       <= 1'b0;
      BUSY     <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            owner <= pick;
            GNT   <= 3'b001 << pick;
            RDY   <= 3'b001 << pick;
            CS    <= 1'b0;
            BUSY  <= 1'b1;
            state <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (!REQ[owner]) begin
            GNT      <= '0;
            RDY      <= '0;
            CS       <= 1'b1;
            BUSY     <= 1'b0;
            half_cnt <= '0;
            state    <= RELEASE;
          end else if (VALID[owner]) begin
            // Accept: first falling SCLK edge presents the MSB.
            shreg    <= owner_byte;
            SDIN     <= owner_byte[7];
            DC       <= DC_IN[owner];
            RDY      <= '0;
            SCLK     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else if (bit_cnt == 3'd7) begin
              RDY   <= GNT;
              state <= WAIT_BYTE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              SCLK    <= 1'b0;
              SDIN    <= shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (half_cnt == HALF_LAST) state <= IDLE;
          else                       half_cnt <= half_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// tb_oled_spi_arbiter: directed table of arbitration/byte transactions plus
// hand-written burst, drop-mid-byte, non-owner strobe and reset sequences.
module tb_oled_spi_arbiter;

  localparam int H = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  REQ, GNT, VALID, RDY, DC_IN;
  logic [23:0] DATA_IN;
  logic        CS, SCLK, SDIN, DC, BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  oled_spi_arbiter #(.SCLK_HALF(H)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .VALID(VALID), .RDY(RDY),
    .DATA_IN(DATA_IN), .DC_IN(DC_IN), .CS(CS), .SCLK(SCLK), .SDIN(SDIN),
    .DC(DC), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] req;
    logic [7:0] data;
    logic       dc;
    logic [2:0] exp_gnt;
    int         exp_zeros;
  } txn_t;

  txn_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Owner lane carries d, other lanes carry ~d so a wrong lane is visible.
  function automatic logic [23:0] lanes(input logic [2:0] sel, input logic [7:0] d);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = sel[i] ? d : ~d;
    return r;
  endfunction

  task automatic wait_grant(output int zeros);
    zeros = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (GNT != 3'b000) return;
      zeros++;
    end
    fail_now("grant");
  endtask

  // Called at a negedge where the byte will be accepted on the next edge.
  task automatic run_byte(input bit hold_valid, input int drop_at,
                          output logic [7:0] bits, output int nbits,
                          output int cycles, output int bad);
    logic ps, pd;
    ps = SCLK; pd = SDIN;
    bits = '0; nbits = 0; cycles = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!hold_valid) VALID = 3'b000;
      if (SDIN !== pd && !(ps === 1'b1 && SCLK === 1'b0)) bad++;
      if (ps === 1'b0 && SCLK === 1'b1) begin
        bits = {bits[6:0], SDIN};
        nbits++;
        if (nbits == drop_at) REQ = 3'b000;
      end
      ps = SCLK; pd = SDIN;
      if (RDY != 3'b000) return;
      cycles++;
    end
    fail_now("byte_end");
  endtask

  task automatic do_txn(input txn_t t);
    int zeros, nbits, cycles, bad;
    logic [7:0] bits;
    REQ     = t.req;
    VALID   = t.req;
    DATA_IN = lanes(t.exp_gnt, t.data);
    DC_IN   = t.dc ? t.exp_gnt : ~t.exp_gnt;
    wait_grant(zeros);
    check("txn_gnt", GNT, t.exp_gnt);
    check("txn_gap_before_grant", zeros, t.exp_zeros);
    check("txn_cs_low", CS, 1'b0);
    check("txn_busy", BUSY, 1'b1);
    check("txn_rdy", RDY, t.exp_gnt);
    run_byte(1'b0, -1, bits, nbits, cycles, bad);
    check("txn_bits", bits, t.data);
    check("txn_nbits", nbits, 8);
    check("txn_shift_cycles", cycles, 16 * H);
    check("txn_sdin_edge", bad, 0);
    check("txn_dc", DC, t.dc);
    check("txn_rdy_back", RDY, t.exp_gnt);
    REQ   = 3'b000;
    VALID = 3'b000;
    @(negedge CLK);
    check("rel_gnt", GNT, 3'b000);
    check("rel_cs", CS, 1'b1);
    check("rel_busy", BUSY, 1'b0);
    check("rel_rdy", RDY, 3'b000);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros, nbits, cycles, bad, phase, gap, cs_bad, nb, sclk_low, rdy2, rises;
    logic [7:0]  bits;
    logic [15:0] bits16;
    logic        ps;

    // Round-robin order after reset: last owner 2, so 0 first.
    tbl[0] = '{3'b001, 8'hA5, 1'b0, 3'b001, 0};
    tbl[1] = '{3'b111, 8'h3C, 1'b1, 3'b010, H};
    tbl[2] = '{3'b111, 8'h81, 1'b0, 3'b100, H};
    tbl[3] = '{3'b111, 8'h7E, 1'b1, 3'b001, H};
    tbl[4] = '{3'b101, 8'h00, 1'b0, 3'b100, H};
    tbl[5] = '{3'b110, 8'hFF, 1'b1, 3'b010, H};
    tbl[6] = '{3'b001, 8'h5A, 1'b1, 3'b001, H};

    RST = 1'b1; REQ = '0; VALID = '0; DATA_IN = '0; DC_IN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_gnt", GNT, 3'b000);
    check("rst_rdy", RDY, 3'b000);
    check("rst_cs", CS, 1'b1);
    check("rst_sclk", SCLK, 1'b1);
    check("rst_sdin", SDIN, 1'b0);
    check("rst_dc", DC, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    // Burst: requester 1, 0x00 then 0xFF, VALID held, DC_IN=1.
    REQ = 3'b010; VALID = 3'b010; DC_IN = 3'b010;
    DATA_IN = lanes(3'b010, 8'h00);
    wait_grant(zeros);
    check("burst_gnt", GNT, 3'b010);
    phase = 0; gap = 0; cs_bad = 0; nb = 0; bits16 = '0; ps = SCLK;
    for (int i = 0; i < 400 && phase != 4; i++) begin
      @(negedge CLK);
      if (CS !== 1'b0) cs_bad++;
      if (ps === 1'b0 && SCLK === 1'b1) begin
        bits16 = {bits16[14:0], SDIN};
        nb++;
      end
      ps = SCLK;
      case (phase)
        0: if (RDY == 3'b000) phase = 1;
        1: if (RDY != 3'b000) begin
             phase = 2; gap = 1;
             DATA_IN[15:8] = 8'hFF;
           end
        2: if (RDY == 3'b000) begin
             phase = 3; VALID = 3'b000;
           end else gap++;
        default: if (RDY != 3'b000) phase = 4;
      endcase
    end
    if (phase != 4) fail_now("burst_end");
    check("burst_bits", bits16, 16'h00FF);
    check("burst_nbits", nb, 16);
    check("burst_gap", gap, 1);
    check("burst_cs_held", cs_bad, 0);
    check("burst_dc", DC, 1'b1);
    REQ = 3'b000;
    @(negedge CLK);
    check("burst_rel_cs", CS, 1'b1);

    // Drop REQ[0] during the byte: byte completes, then a SCLK_HALF release.
    REQ = 3'b001; VALID = 3'b001; DC_IN = 3'b000;
    DATA_IN = lanes(3'b001, 8'hC3);
    wait_grant(zeros);
    check("drop_gnt", GNT, 3'b001);
    check("drop_gap", zeros, H);
    run_byte(1'b0, 3, bits, nbits, cycles, bad);
    check("drop_bits", bits, 8'hC3);
    check("drop_nbits", nbits, 8);
    check("drop_shift_cycles", cycles, 16 * H);
    @(negedge CLK);
    check("drop_rel_cs", CS, 1'b1);
    check("drop_rel_gnt", GNT, 3'b000);
    REQ = 3'b001;
    wait_grant(zeros);
    check("drop_release_len", zeros, H);
    check("drop_regrant", GNT, 3'b001);
    REQ = 3'b000;
    repeat (H + 2) @(negedge CLK);

    // Strobe from non-owner 2 while requester 0 owns the bus.
    REQ = 3'b001; VALID = 3'b100; DATA_IN = lanes(3'b100, 8'h11);
    wait_grant(zeros);
    check("strobe_gnt", GNT, 3'b001);
    sclk_low = 0; rdy2 = 0;
    repeat (8) begin
      @(negedge CLK);
      if (SCLK !== 1'b1) sclk_low++;
      if (RDY[2] !== 1'b0) rdy2++;
    end
    check("strobe_no_sclk", sclk_low, 0);
    check("strobe_rdy2", rdy2, 0);
    check("strobe_rdy_owner", RDY, 3'b001);
    REQ = 3'b000; VALID = 3'b000;
    repeat (H + 2) @(negedge CLK);

    // Reset after the 5th SCLK rise of a byte.
    REQ = 3'b001; VALID = 3'b001; DC_IN = 3'b001;
    DATA_IN = lanes(3'b001, 8'h96);
    wait_grant(zeros);
    check("rstmid_gnt", GNT, 3'b001);
    rises = 0; ps = SCLK;
    for (int i = 0; i < 400 && rises < 5; i++) begin
      @(negedge CLK);
      VALID = 3'b000;
      if (ps === 1'b0 && SCLK === 1'b1) rises++;
      ps = SCLK;
    end
    if (rises < 5) fail_now("rstmid_rises");
    check("rstmid_dc_before", DC, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_cs", CS, 1'b1);
    check("rstmid_sclk", SCLK, 1'b1);
    check("rstmid_gnt0", GNT, 3'b000);
    check("rstmid_rdy", RDY, 3'b000);
    check("rstmid_dc", DC, 1'b0);
    check("rstmid_sdin", SDIN, 1'b0);
    check("rstmid_busy", BUSY, 1'b0);
    RST = 1'b0; REQ = 3'b000;
    sclk_low = 0;
    repeat (6) begin
      @(negedge CLK);
      if (SCLK !== 1'b1) sclk_low++;
    end
    check("rstmid_quiet", sclk_low, 0);
    // Both 0 and 1 request: last owner back at 2 means 0 wins.
    REQ = 3'b011;
    wait_grant(zeros);
    check("rstmid_regrant", GNT, 3'b001);
    REQ = 3'b000;
    repeat (H + 2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
